controle_divisor_serial: RTL

- Sequencer for the shared 8-bit add/sub unit: runs an unsigned restoring divide, one quotient bit per clock.
- Drives the unit's a, b and op inputs and reads its 9-bit result. Bit 8 of that result is the carry on add and the borrow (a<b) on subtract.
- Sits between the coprocessor command decoder (start/operands) and the result register bank.

---
 rtl/controle_divisor_serial.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/controle_divisor_serial.sv
// Serial sequencer for the shared add/sub unit: unsigned restoring divide, one quotient bit per clock.
// Define CONTROLE_DIVISOR_MULT_EN to add a shift-add multiply mode selected by the modo input.
module controle_divisor_serial #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inicio,
`ifdef CONTROLE_DIVISOR_MULT_EN
  input  logic              modo,
`endif
  input  logic [DATA_W-1:0] dividendo,
  input  logic [DATA_W-1:0] divisor,
  output logic              ocupado,
  output logic              pronto,
  output logic              div_zero,
  output logic [DATA_W-1:0] quociente,
  output logic [DATA_W-1:0] resto,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_op,
  input  logic [DATA_W:0]   alu_resultado
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] r_reg, r_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic [DATA_W-1:0] d_reg, d_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mult_reg, mult_next;
  logic [DATA_W-1:0] quoc_reg, quoc_next;
  logic [DATA_W-1:0] resto_reg, resto_next;
  logic              dz_reg, dz_next;
  logic              ocupado_reg, pronto_reg;
  logic [DATA_W:0]   sh;
  logic              take;
  logic              start_mult;

`ifdef CONTROLE_DIVISOR_MULT_EN
  assign start_mult = modo;
`else
  assign start_mult = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    mult_next  = mult_reg;
    quoc_next  = quoc_reg;
    resto_next = resto_reg;
    dz_next    = dz_reg;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 1'b0;
    take       = 1'b0;
    sh         = {r_reg, q_reg[DATA_W-1]};
    case (state_reg)
      IDLE: begin
        if (inicio) begin
          if (divisor == '0 && !start_mult) begin
            state_next = FIM;
            quoc_next  = '1;
            resto_next = dividendo;
            dz_next    = 1'b1;
          end else begin
            state_next = CALC;
            r_next     = '0;
            q_next     = dividendo;
            d_next     = divisor;
            cnt_next   = CNT_W'(DATA_W - 1);
            mult_next  = start_mult;
            dz_next    = 1'b0;
          end
        end
      end
      CALC: begin
        if (mult_reg) begin
          // The 9-bit sum shifts right through the {H,L} pair.
          alu_op = 1'b0;
          alu_a  = r_reg;
          alu_b  = q_reg[0] ? d_reg : '0;
          r_next = alu_resultado[DATA_W:1];
          q_next = {alu_resultado[0], q_reg[DATA_W-1:1]};
        end else begin
          alu_op = 1'b1;
          alu_a  = sh[DATA_W-1:0];
          alu_b  = d_reg;
          // A set shifted-out bit means sh >= D even though the 8-bit subtract borrowed.
          take   = sh[DATA_W] | ~alu_resultado[DATA_W];
          if (take) begin
            r_next = alu_resultado[DATA_W-1:0];
            q_next = {q_reg[DATA_W-2:0], 1'b1};
          end else begin
            r_next = sh[DATA_W-1:0];
            q_next = {q_reg[DATA_W-2:0], 1'b0};
          end
        end
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          quoc_next  = q_next;
          resto_next = r_next;
          state_next = FIM;
        end
      end
      FIM: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      mult_reg    <= 1'b0;
      quoc_reg    <= '0;
      resto_reg   <= '0;
      dz_reg      <= 1'b0;
      ocupado_reg <= 1'b0;
      pronto_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      r_reg       <= r_next;
      q_reg       <= q_next;
      d_reg       <= d_next;
      cnt_reg     <= cnt_next;
      mult_reg    <= mult_next;
      quoc_reg    <= quoc_next;
      resto_reg   <= resto_next;
      dz_reg      <= dz_next;
      ocupado_reg <= (state_next == CALC);
      pronto_reg  <= (state_next == FIM);
    end
  end

  assign ocupado   = ocupado_reg;
  assign pronto    = pronto_reg;
  assign div_zero  = dz_reg;
  assign quociente = quoc_reg;
  assign resto     = resto_reg;

endmodule
